// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two cache controllers, the shared memory port and the arbiter.
// The arbiter takes the slave view; the cache/memory side takes the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic              i_rd;
    logic              i_wr;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_data_in;
    logic              i_gnt;
    logic              i_stall;
    logic [DATA_W-1:0] i_data_out;
    logic              i_rdata_vld;

    logic              d_req;
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_data_in;
    logic              d_gnt;
    logic              d_stall;
    logic [DATA_W-1:0] d_data_out;
    logic              d_rdata_vld;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_wr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_stall;

    modport slave (
        input  i_req, i_rd, i_wr, i_addr, i_data_in,
        output i_gnt, i_stall, i_data_out, i_rdata_vld,
        input  d_req, d_rd, d_wr, d_addr, d_data_in,
        output d_gnt, d_stall, d_data_out, d_rdata_vld,
        output mem_addr, mem_data_in, mem_wr, mem_rd,
        input  mem_data_out, mem_stall
    );

    modport master (
        output i_req, i_rd, i_wr, i_addr, i_data_in,
        input  i_gnt, i_stall, i_data_out, i_rdata_vld,
        output d_req, d_rd, d_wr, d_addr, d_data_in,
        input  d_gnt, d_stall, d_data_out, d_rdata_vld,
        input  mem_addr, mem_data_in, mem_wr, mem_rd,
        output mem_data_out, mem_stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between I-cache and D-cache
// controllers; grants are held per burst and read returns are steered by a tagged return pipe.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input logic clk,
    input logic rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DRAIN} state_t;

    state_t state, state_nxt;
    logic   last_d, last_d_nxt;

    // Return pipe: index 0 is pushed this edge, index MEM_LAT-1 is the head.
    logic [MEM_LAT-1:0] ret_vld_p;
    logic [MEM_LAT-1:0] ret_own_p;

    logic              busy_nxt;
    logic              push;
    logic              rd_sel;
    logic              wr_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              head_i;
    logic              head_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
        end
    end

    // Owner tag rides alongside vld and needs no reset: vld gates it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ret_vld_p <= '0;
        end else begin
            ret_vld_p[0] <= push;
            for (int k = 1; k < MEM_LAT; k++) begin
                ret_vld_p[k] <= ret_vld_p[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        ret_own_p[0] <= (state == GRANT_D);
        for (int k = 1; k < MEM_LAT; k++) begin
            ret_own_p[k] <= ret_own_p[k-1];
        end
    end

    // Pipe still holds a read after the coming edge (the head retires this cycle).
    always_comb begin
        busy_nxt = 1'b0;
        for (int k = 0; k < MEM_LAT - 1; k++) begin
            busy_nxt = busy_nxt | ret_vld_p[k];
        end
    end

    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        case (state)
            IDLE: begin
                if (bus.i_req && bus.d_req) begin
                    state_nxt = last_d ? GRANT_I : GRANT_D;
                end else if (bus.i_req) begin
                    state_nxt = GRANT_I;
                end else if (bus.d_req) begin
                    state_nxt = GRANT_D;
                end
            end
            GRANT_I: begin
                if (!bus.i_req) begin
                    last_d_nxt = 1'b0;
                    if (busy_nxt) begin
                        state_nxt = DRAIN;
                    end else if (bus.d_req) begin
                        state_nxt = GRANT_D;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GRANT_D: begin
                if (!bus.d_req) begin
                    last_d_nxt = 1'b1;
                    if (busy_nxt) begin
                        state_nxt = DRAIN;
                    end else if (bus.i_req) begin
                        state_nxt = GRANT_I;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (!busy_nxt) begin
                    if (last_d ? bus.i_req : bus.d_req) begin
                        state_nxt = last_d ? GRANT_I : GRANT_D;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write beats read when both strobes arrive together; a dropping req kills its strobes.
    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        rd_sel    = 1'b0;
        wr_sel    = 1'b0;
        case (state)
            GRANT_I: begin
                addr_sel  = bus.i_addr;
                wdata_sel = bus.i_data_in;
                wr_sel    = bus.i_req & bus.i_wr;
                rd_sel    = bus.i_req & bus.i_rd & ~bus.i_wr;
            end
            GRANT_D: begin
                addr_sel  = bus.d_addr;
                wdata_sel = bus.d_data_in;
                wr_sel    = bus.d_req & bus.d_wr;
                rd_sel    = bus.d_req & bus.d_rd & ~bus.d_wr;
            end
            default: ;
        endcase
    end

    assign push            = rd_sel & ~bus.mem_stall;
    assign bus.mem_addr    = addr_sel;
    assign bus.mem_data_in = wdata_sel;
    assign bus.mem_rd      = rd_sel;
    assign bus.mem_wr      = wr_sel;

    assign bus.i_gnt   = (state == GRANT_I);
    assign bus.d_gnt   = (state == GRANT_D);
    assign bus.i_stall = bus.i_req & (~bus.i_gnt | bus.mem_stall);
    assign bus.d_stall = bus.d_req & (~bus.d_gnt | bus.mem_stall);

    assign head_i          = ret_vld_p[MEM_LAT-1] & ~ret_own_p[MEM_LAT-1];
    assign head_d          = ret_vld_p[MEM_LAT-1] &  ret_own_p[MEM_LAT-1];
    assign bus.i_rdata_vld = head_i;
    assign bus.d_rdata_vld = head_d;
    assign bus.i_data_out  = head_i ? bus.mem_data_out : '0;
    assign bus.d_data_out  = head_d ? bus.mem_data_out : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: tie-break, D read burst with drain handoff,
// memory stall, alternating write bursts and reset with reads in flight.
module tb_mem_port_arbiter;
    localparam int MEM_LAT = 2;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   dpulses = 0;
    int   ipulses = 0;
    logic cur_d;
    logic exp_d;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .ADDR_W(16), .DATA_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: returns addr^0xFFFF two cycles after an accepted read.
    logic        mq_v0 = 1'b0;
    logic        mq_v1 = 1'b0;
    logic [15:0] mq_a0 = 16'h0000;
    logic [15:0] mq_a1 = 16'h0000;
    always @(posedge clk) begin
        mq_v0 <= bus.mem_rd & ~bus.mem_stall;
        mq_a0 <= bus.mem_addr;
        mq_v1 <= mq_v0;
        mq_a1 <= mq_a0;
    end
    assign bus.mem_data_out = mq_v1 ? (mq_a1 ^ 16'hFFFF) : 16'h0000;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ret(input string tag, input logic ivld, input logic [15:0] idat,
                           input logic dvld, input logic [15:0] ddat);
        if (bus.i_rdata_vld === 1'b1) ipulses++;
        if (bus.d_rdata_vld === 1'b1) dpulses++;
        chk1 ({tag, "_i_vld"},  bus.i_rdata_vld, ivld);
        chk16({tag, "_i_data"}, bus.i_data_out,  idat);
        chk1 ({tag, "_d_vld"},  bus.d_rdata_vld, dvld);
        chk16({tag, "_d_data"}, bus.d_data_out,  ddat);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.i_req = 1'b0; bus.i_rd = 1'b0; bus.i_wr = 1'b0;
        bus.i_addr = 16'h0000; bus.i_data_in = 16'h0000;
        bus.d_req = 1'b0; bus.d_rd = 1'b0; bus.d_wr = 1'b0;
        bus.d_addr = 16'h0000; bus.d_data_in = 16'h0000;
        bus.mem_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1 ("rst_i_gnt",  bus.i_gnt,  1'b0);
        chk1 ("rst_d_gnt",  bus.d_gnt,  1'b0);
        chk1 ("rst_mem_rd", bus.mem_rd, 1'b0);
        chk1 ("rst_mem_wr", bus.mem_wr, 1'b0);
        chk16("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk_ret("rst", 1'b0, 16'h0000, 1'b0, 16'h0000);

        // Both request together out of reset: D wins, I waits with its read held.
        rst_n = 1'b1;
        bus.i_req = 1'b1; bus.i_rd = 1'b1; bus.i_addr = 16'h0100;
        bus.d_req = 1'b1;
        #1;
        chk1("tie_i_gnt",   bus.i_gnt,   1'b0);
        chk1("tie_d_gnt",   bus.d_gnt,   1'b0);
        chk1("tie_mem_rd",  bus.mem_rd,  1'b0);
        chk1("tie_i_stall", bus.i_stall, 1'b1);

        cyc(); bus.d_rd = 1'b1; bus.d_addr = 16'h0010; #1;
        chk1 ("c1_d_gnt",   bus.d_gnt,   1'b1);
        chk1 ("c1_i_gnt",   bus.i_gnt,   1'b0);
        chk1 ("c1_i_stall", bus.i_stall, 1'b1);
        chk1 ("c1_d_stall", bus.d_stall, 1'b0);
        chk1 ("c1_mem_rd",  bus.mem_rd,  1'b1);
        chk16("c1_mem_addr", bus.mem_addr, 16'h0010);
        chk_ret("c1", 1'b0, 16'h0000, 1'b0, 16'h0000);

        cyc(); bus.d_addr = 16'h0012; #1;
        chk16("c2_mem_addr", bus.mem_addr, 16'h0012);
        chk_ret("c2", 1'b0, 16'h0000, 1'b0, 16'h0000);

        cyc(); bus.d_addr = 16'h0014; #1;
        chk16("c3_mem_addr", bus.mem_addr, 16'h0014);
        chk_ret("c3", 1'b0, 16'h0000, 1'b1, 16'hFFEF);

        cyc(); bus.d_addr = 16'h0016; #1;
        chk16("c4_mem_addr", bus.mem_addr, 16'h0016);
        chk_ret("c4", 1'b0, 16'h0000, 1'b1, 16'hFFED);

        // D ends its burst with a read still in flight: expect DRAIN before I gets the port.
        cyc(); bus.d_req = 1'b0; bus.d_rd = 1'b0; #1;
        chk1("c5_d_gnt",  bus.d_gnt,  1'b1);
        chk1("c5_mem_rd", bus.mem_rd, 1'b0);
        chk_ret("c5", 1'b0, 16'h0000, 1'b1, 16'hFFEB);

        cyc(); #1;
        chk1("c6_d_gnt",   bus.d_gnt,   1'b0);
        chk1("c6_i_gnt",   bus.i_gnt,   1'b0);
        chk1("c6_mem_rd",  bus.mem_rd,  1'b0);
        chk1("c6_i_stall", bus.i_stall, 1'b1);
        chk_ret("c6", 1'b0, 16'h0000, 1'b1, 16'hFFE9);

        cyc(); #1;
        chk1 ("c7_i_gnt",   bus.i_gnt,   1'b1);
        chk1 ("c7_i_stall", bus.i_stall, 1'b0);
        chk1 ("c7_mem_rd",  bus.mem_rd,  1'b1);
        chk16("c7_mem_addr", bus.mem_addr, 16'h0100);
        chk_ret("c7", 1'b0, 16'h0000, 1'b0, 16'h0000);
        chk16("d_pulse_count", 16'(dpulses), 16'd4);

        // Three cycles of bank conflict on the next I read.
        cyc(); bus.i_addr = 16'h0102; bus.mem_stall = 1'b1; #1;
        chk1("c8_i_stall", bus.i_stall, 1'b1);
        chk_ret("c8", 1'b0, 16'h0000, 1'b0, 16'h0000);

        cyc(); #1;
        chk1("c9_i_stall", bus.i_stall, 1'b1);
        chk_ret("c9", 1'b1, 16'hFEFF, 1'b0, 16'h0000);

        ipulses = 0;
        cyc(); #1;
        chk1("c10_i_stall", bus.i_stall, 1'b1);
        chk_ret("c10", 1'b0, 16'h0000, 1'b0, 16'h0000);

        cyc(); bus.mem_stall = 1'b0; #1;
        chk1 ("c11_i_stall", bus.i_stall, 1'b0);
        chk16("c11_mem_addr", bus.mem_addr, 16'h0102);
        chk_ret("c11", 1'b0, 16'h0000, 1'b0, 16'h0000);

        cyc(); bus.i_rd = 1'b0; bus.d_req = 1'b1; #1;
        chk1("c12_d_stall", bus.d_stall, 1'b1);
        chk_ret("c12", 1'b0, 16'h0000, 1'b0, 16'h0000);

        cyc(); #1;
        chk_ret("c13", 1'b1, 16'hFEFD, 1'b0, 16'h0000);
        chk16("i_pulse_after_stall", 16'(ipulses), 16'd1);

        // Write bursts with both requests held: ownership must alternate D, I, D, I.
        cur_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (cur_d) begin
                bus.d_rd = 1'b1; bus.d_wr = 1'b1;
                bus.d_addr = 16'(32'h0200 + k); bus.d_data_in = 16'(32'hA500 + k);
            end else begin
                bus.i_rd = 1'b1; bus.i_wr = 1'b1;
                bus.i_addr = 16'(32'h0200 + k); bus.i_data_in = 16'(32'hA500 + k);
            end
            #1;
            chk1 ("alt_mem_wr",  bus.mem_wr, 1'b1);
            chk1 ("alt_mem_rd",  bus.mem_rd, 1'b0);
            chk16("alt_mem_addr", bus.mem_addr, 16'(32'h0200 + k));
            chk16("alt_mem_wdata", bus.mem_data_in, 16'(32'hA500 + k));
            chk1 ("alt_owner_gnt", cur_d ? bus.d_gnt : bus.i_gnt, 1'b1);
            chk1 ("alt_other_stall", cur_d ? bus.i_stall : bus.d_stall, 1'b1);

            cyc();
            if (cur_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
            #1;
            chk1("alt_drop_mem_wr", bus.mem_wr, 1'b0);
            chk1("alt_drop_mem_rd", bus.mem_rd, 1'b0);

            cyc();
            bus.i_req = 1'b1; bus.d_req = 1'b1;
            bus.i_rd = 1'b0; bus.i_wr = 1'b0; bus.d_rd = 1'b0; bus.d_wr = 1'b0;
            #1;
            exp_d = (k % 2 == 0);
            chk1("alt_d_gnt", bus.d_gnt, exp_d);
            chk1("alt_i_gnt", bus.i_gnt, !exp_d);
            chk_ret("alt", 1'b0, 16'h0000, 1'b0, 16'h0000);
            cur_d = exp_d;
        end

        // Two I reads in flight when reset hits: neither may come back.
        cyc(); bus.d_req = 1'b0; bus.i_rd = 1'b1; bus.i_addr = 16'h0300; #1;
        chk1("r1_i_gnt",  bus.i_gnt,  1'b1);
        chk1("r1_mem_rd", bus.mem_rd, 1'b1);

        cyc(); bus.i_addr = 16'h0302; rst_n = 1'b0; #1;
        chk1("r2_mem_rd", bus.mem_rd, 1'b1);

        cyc(); rst_n = 1'b1; bus.i_req = 1'b0; bus.i_rd = 1'b0; #1;
        chk1("r3_i_gnt",  bus.i_gnt,  1'b0);
        chk1("r3_d_gnt",  bus.d_gnt,  1'b0);
        chk1("r3_mem_rd", bus.mem_rd, 1'b0);
        chk_ret("r3", 1'b0, 16'h0000, 1'b0, 16'h0000);

        cyc(); #1;
        chk_ret("r4", 1'b0, 16'h0000, 1'b0, 16'h0000);

        cyc(); #1;
        chk_ret("r5", 1'b0, 16'h0000, 1'b0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
